fp_round_pipe: RTL and testbench

- Parametrised, pipelined rounding stage for the floating-point divider datapath; next generation of the fixed 4-bit, round-half-up rounding stage.
- Takes a sign/exponent/fraction result plus an external sticky bit.
- Rounds the fraction to KEEP_W most-significant bits using one of four IEEE rounding modes.
- Propagates fraction carry into the exponent, saturates overflow to infinity, and flags inexact/overflow. Valid/ready handshake, 2-cycle latency.

---
 rtl/fp_round_pipe.sv | 119 +++++++++++
 tb/tb_fp_round_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE rounding stage for the FP divider: keeps KEEP_W fraction MSBs,
// pushes any fraction carry into the exponent and saturates overflow to infinity.
module fp_round_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int KEEP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic             in_sticky,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_inexact,
    output logic             out_overflow
);

    localparam int LOW_W = MAN_W - KEEP_W;

    logic adv1, adv2;
    logic g, s, inc;

    logic             v1;
    logic             sign1;
    logic [EXP_W-1:0] exp1;
    logic [MAN_W-1:0] man1;
    logic             inc1;
    logic             inexact1;
    logic             special1;

    logic [KEEP_W:0]  sum;
    logic [EXP_W-1:0] exp_r;
    logic             sat;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~v1 | adv2;
    assign in_ready = adv1;

    assign g = in_man[LOW_W-1];

    // With a single discarded bit there is nothing below the guard bit.
    generate
        if (LOW_W > 1) begin : g_low_sticky
            assign s = (|in_man[LOW_W-2:0]) | in_sticky;
        end else begin : g_ext_sticky
            assign s = in_sticky;
        end
    endgenerate

    always_comb begin
        inc = 1'b0;
        case (in_mode)
            2'b00:   inc = g & (s | in_man[LOW_W]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~in_sign & (g | s);
            default: inc = in_sign & (g | s);
        endcase
    end

    // Full fraction is kept in stage 1 so Inf/NaN payloads pass through intact.
    assign sum   = {1'b0, man1[MAN_W-1 -: KEEP_W]} + {{KEEP_W{1'b0}}, inc1};
    assign exp_r = exp1 + {{(EXP_W-1){1'b0}}, sum[KEEP_W]};
    assign sat   = &exp_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1           <= 1'b0;
            out_valid    <= 1'b0;
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_man      <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    sign1    <= in_sign;
                    exp1     <= in_exp;
                    man1     <= in_man;
                    inc1     <= inc;
                    inexact1 <= g | s;
                    special1 <= &in_exp;
                end
            end
            if (adv2) begin
                out_valid <= v1;
                if (v1) begin
                    out_sign <= sign1;
                    if (special1) begin
                        out_exp      <= exp1;
                        out_man      <= man1;
                        out_inexact  <= 1'b0;
                        out_overflow <= 1'b0;
                    end else if (sat) begin
                        out_exp      <= '1;
                        out_man      <= '0;
                        out_inexact  <= 1'b1;
                        out_overflow <= 1'b1;
                    end else begin
                        out_exp      <= exp_r;
                        out_man      <= {sum[KEEP_W-1:0], {LOW_W{1'b0}}};
                        out_inexact  <= inexact1;
                        out_overflow <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed rounding cases on the default build plus
// randomized handshake traffic on default and wide (52/11/51) builds.
module tb_fp_round_pipe;

    localparam int AE = 8,  AM = 23, AK = 4;
    localparam int BE = 11, BM = 52, BK = 51;

    typedef struct {
        logic        sign;
        logic [63:0] e;
        logic [63:0] m;
        logic        inx;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_in_valid = 0, a_in_ready, a_in_sign = 0, a_in_sticky = 0;
    logic [AE-1:0] a_in_exp = '0;
    logic [AM-1:0] a_in_man = '0;
    logic [1:0]    a_in_mode = '0;
    logic          a_out_valid, a_out_ready = 1, a_out_sign, a_out_inexact, a_out_overflow;
    logic [AE-1:0] a_out_exp;
    logic [AM-1:0] a_out_man;

    logic          b_in_valid = 0, b_in_ready, b_in_sign = 0, b_in_sticky = 0;
    logic [BE-1:0] b_in_exp = '0;
    logic [BM-1:0] b_in_man = '0;
    logic [1:0]    b_in_mode = '0;
    logic          b_out_valid, b_out_ready = 1, b_out_sign, b_out_inexact, b_out_overflow;
    logic [BE-1:0] b_out_exp;
    logic [BM-1:0] b_out_man;

    fp_round_pipe #(.EXP_W(AE), .MAN_W(AM), .KEEP_W(AK)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sign(a_in_sign),
        .in_exp(a_in_exp), .in_man(a_in_man), .in_sticky(a_in_sticky), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sign(a_out_sign),
        .out_exp(a_out_exp), .out_man(a_out_man), .out_inexact(a_out_inexact),
        .out_overflow(a_out_overflow)
    );

    fp_round_pipe #(.EXP_W(BE), .MAN_W(BM), .KEEP_W(BK)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sign(b_in_sign),
        .in_exp(b_in_exp), .in_man(b_in_man), .in_sticky(b_in_sticky), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sign(b_out_sign),
        .out_exp(b_out_exp), .out_man(b_out_man), .out_inexact(b_out_inexact),
        .out_overflow(b_out_overflow)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference: truncate, then compare the discarded remainder against one half ulp.
    function automatic res_t model(input int ew, input int mw, input int kw, input logic s,
                                   input logic [63:0] e, input logic [63:0] m,
                                   input logic st, input logic [1:0] md);
        res_t r;
        logic [63:0] emax, trunc, rem, half, e_out;
        logic inc, nz, tie, above;
        int sh;
        emax = (64'd1 << ew) - 64'd1;
        sh = mw - kw;
        r.sign = s;
        if (e == emax) begin
            r.e = e; r.m = m; r.inx = 1'b0; r.ovf = 1'b0;
            return r;
        end
        trunc = m >> sh;
        rem   = m & ((64'd1 << sh) - 64'd1);
        half  = 64'd1 << (sh - 1);
        nz    = (rem != 0) || st;
        tie   = (rem == half) && !st;
        above = (rem > half) || ((rem == half) && st);
        case (md)
            2'd0:    inc = above || (tie && trunc[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = nz && !s;
            default: inc = nz && s;
        endcase
        trunc = trunc + {63'd0, inc};
        e_out = e;
        if (trunc == (64'd1 << kw)) begin
            trunc = 64'd0;
            e_out = e + 64'd1;
        end
        r.inx = nz;
        if (e_out == emax) begin
            r.e = emax; r.m = 64'd0; r.ovf = 1'b1;
        end else begin
            r.e = e_out; r.m = trunc << sh; r.ovf = 1'b0;
        end
        return r;
    endfunction

    res_t qa[$], qb[$];
    res_t ra, rb;
    logic        a_stall = 0, b_stall = 0;
    logic [127:0] a_prev, b_prev, a_vec, b_vec;
    int a_acc = 0, b_acc = 0;

    assign a_vec = 128'({a_out_valid, a_out_sign, a_out_exp, a_out_man, a_out_inexact, a_out_overflow});
    assign b_vec = 128'({b_out_valid, b_out_sign, b_out_exp, b_out_man, b_out_inexact, b_out_overflow});

    always @(negedge clk) begin
        if (rst) begin
            qa.delete(); qb.delete();
            a_stall = 0; b_stall = 0;
        end else begin
            check("a_in_ready", a_in_ready, !(qa.size() == 2 && !a_out_ready));
            check("b_in_ready", b_in_ready, !(qb.size() == 2 && !b_out_ready));
            if (a_stall) check("a_stall_stable", a_vec, a_prev);
            if (b_stall) check("b_stall_stable", b_vec, b_prev);
            if (a_out_valid && a_out_ready) begin
                check("a_out_expected", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    ra = qa.pop_front();
                    check("a_sign", a_out_sign, ra.sign);
                    check("a_exp", a_out_exp, ra.e);
                    check("a_man", a_out_man, ra.m);
                    check("a_inexact", a_out_inexact, ra.inx);
                    check("a_overflow", a_out_overflow, ra.ovf);
                end
            end
            if (b_out_valid && b_out_ready) begin
                check("b_out_expected", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    rb = qb.pop_front();
                    check("b_sign", b_out_sign, rb.sign);
                    check("b_exp", b_out_exp, rb.e);
                    check("b_man", b_out_man, rb.m);
                    check("b_inexact", b_out_inexact, rb.inx);
                    check("b_overflow", b_out_overflow, rb.ovf);
                end
            end
            a_stall = a_out_valid && !a_out_ready;
            b_stall = b_out_valid && !b_out_ready;
            a_prev = a_vec;
            b_prev = b_vec;
            if (a_in_valid && a_in_ready) begin
                qa.push_back(model(AE, AM, AK, a_in_sign, 64'(a_in_exp), 64'(a_in_man), a_in_sticky, a_in_mode));
                a_acc++;
            end
            if (b_in_valid && b_in_ready) begin
                qb.push_back(model(BE, BM, BK, b_in_sign, 64'(b_in_exp), 64'(b_in_man), b_in_sticky, b_in_mode));
                b_acc++;
            end
        end
    end

    task automatic directed(input string tag, input logic s, input logic [AE-1:0] e,
                            input logic [AM-1:0] m, input logic st, input logic [1:0] md,
                            input logic [AE-1:0] xe, input logic [AM-1:0] xm,
                            input logic xi, input logic xo);
        logic acc, got;
        @(posedge clk); #1;
        a_in_valid = 1; a_in_sign = s; a_in_exp = e; a_in_man = m;
        a_in_sticky = st; a_in_mode = md; a_out_ready = 1;
        acc = 0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
        end
        #1 a_in_valid = 0;
        check({tag, ".accept"}, acc, 1);
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (a_out_valid) begin
                got = 1;
                check({tag, ".sign"}, a_out_sign, s);
                check({tag, ".exp"}, a_out_exp, xe);
                check({tag, ".man"}, a_out_man, xm);
                check({tag, ".inexact"}, a_out_inexact, xi);
                check({tag, ".overflow"}, a_out_overflow, xo);
            end
        end
        check({tag, ".out"}, got, 1);
    endtask

    task automatic rand_inputs();
        a_in_valid  = $urandom_range(0, 3) != 0;
        a_out_ready = $urandom_range(0, 3) != 0;
        a_in_sign   = 1'($urandom);
        a_in_sticky = $urandom_range(0, 3) == 0;
        a_in_mode   = 2'($urandom);
        case ($urandom_range(0, 5))
            0: a_in_exp = '1;
            1: a_in_exp = 8'hFE;
            2: a_in_exp = '0;
            default: a_in_exp = 8'($urandom);
        endcase
        a_in_man = ($urandom_range(0, 3) == 0) ? 23'($urandom) & 23'h7F0000 : 23'($urandom);
        b_in_valid  = $urandom_range(0, 3) != 0;
        b_out_ready = $urandom_range(0, 3) != 0;
        b_in_sign   = 1'($urandom);
        b_in_sticky = $urandom_range(0, 3) == 0;
        b_in_mode   = 2'($urandom);
        case ($urandom_range(0, 5))
            0: b_in_exp = '1;
            1: b_in_exp = 11'h7FE;
            2: b_in_exp = '0;
            default: b_in_exp = 11'($urandom);
        endcase
        b_in_man = ($urandom_range(0, 3) == 0) ? '1 : 52'({$urandom(), $urandom()});
    endtask

    task automatic run_random(input int beats);
        a_acc = 0; b_acc = 0;
        for (int c = 0; c < 30000 && (a_acc < beats || b_acc < beats); c++) begin
            @(posedge clk); #1;
            rand_inputs();
        end
        check("a_beats_done", a_acc >= beats, 1);
        check("b_beats_done", b_acc >= beats, 1);
        @(posedge clk); #1;
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        for (int c = 0; c < 20 && (qa.size() + qb.size()) != 0; c++) @(negedge clk);
        check("drain_empty", qa.size() + qb.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_a_outputs", a_vec, 0);
        check("rst_b_outputs", b_vec, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_in_ready", b_in_ready, 1);

        directed("rne_tie_up",   0, 8'h80, 23'h2C0000, 0, 2'b00, 8'h80, 23'h300000, 1, 0);
        directed("rne_tie_even", 0, 8'h80, 23'h240000, 0, 2'b00, 8'h80, 23'h200000, 1, 0);
        directed("carry_exp",    0, 8'h7F, 23'h7C0000, 0, 2'b00, 8'h80, 23'h000000, 1, 0);
        directed("ovf_rne",      0, 8'hFE, 23'h7C0000, 0, 2'b00, 8'hFF, 23'h000000, 1, 1);
        directed("ovf_rtz",      0, 8'hFE, 23'h7C0000, 0, 2'b01, 8'hFE, 23'h780000, 1, 0);
        directed("pos_rne",      0, 8'h80, 23'h010000, 0, 2'b00, 8'h80, 23'h000000, 1, 0);
        directed("pos_rtz",      0, 8'h80, 23'h010000, 0, 2'b01, 8'h80, 23'h000000, 1, 0);
        directed("pos_rup",      0, 8'h80, 23'h010000, 0, 2'b10, 8'h80, 23'h080000, 1, 0);
        directed("pos_rdn",      0, 8'h80, 23'h010000, 0, 2'b11, 8'h80, 23'h000000, 1, 0);
        directed("neg_rdn",      1, 8'h80, 23'h010000, 0, 2'b11, 8'h80, 23'h080000, 1, 0);
        directed("neg_rup",      1, 8'h80, 23'h010000, 0, 2'b10, 8'h80, 23'h000000, 1, 0);
        directed("special",      0, 8'hFF, 23'h400001, 1, 2'b10, 8'hFF, 23'h400001, 0, 0);
        directed("exact",        1, 8'h80, 23'h300000, 0, 2'b11, 8'h80, 23'h300000, 0, 0);
        directed("subnorm_prom", 0, 8'h00, 23'h7FFFFF, 0, 2'b10, 8'h01, 23'h000000, 1, 0);

        run_random(1000);

        // Fill both pipes under backpressure, then reset mid-stream.
        @(posedge clk); #1;
        a_in_valid = 1; b_in_valid = 1; a_out_ready = 0; b_out_ready = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1; a_in_valid = 0; b_in_valid = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("midrst_a_outputs", a_vec, 0);
        check("midrst_b_outputs", b_vec, 0);
        check("midrst_a_in_ready", a_in_ready, 1);
        check("midrst_b_in_ready", b_in_ready, 1);

        run_random(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
